pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Central stall/flush controller for the 5-stage MIPS core. It merges the per-stage hold requests into the cumulative `stall[3:0]` vector consumed by every pipeline register, runs the multi-cycle divider stall counter, and sequences exceptions. Exception sequencing covers the one-cycle flush, the drain of outstanding AXI instruction fetches, and the PC redirect. It sits beside the pipeline registers (if_id … mem_wb), whose `stall`/`exception` inputs it drives.

## Interface
- `DIV_CYCLES`, 33: cycles the EXE stage is held per divide, counted from the `div_start` cycle inclusive.
- `INST_OUTSTANDING_MAX`, 2: maximum in-flight instruction-fetch AXI reads; range 1–3.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `if_stall_req`  in  1  IF waiting for the instruction bus.
- `id_stall_req`  in  1  load-use hazard in ID.
- `div_start`  in  1  divide accepted in EXE (1-cycle pulse).
- `mem_stall_req`  in  1  data bus transaction pending in MEM.
- `exc_req`  in  1  exception or eret in MEM; held stable by MEM until accepted.
- `exc_target`  in  32  handler/EPC address.
- `inst_req_fire`  in  1  instruction AR handshake.
- `inst_resp_fire`  in  1  instruction R handshake (last beat).
- `stall`  out  4  [0] inst, [1] id, [2] exe, [3] data.
- `flush`  out  1  to the `exception` input of all pipeline registers.
- `inst_req_allow`  out  1  IF may issue a fetch.
- `inst_resp_discard`  out  1  current instruction response is dropped.
- `pc_redirect`  out  1  load `pc_redirect_target` into PC.
- `pc_redirect_target`  out  32  latched `exc_target`.
- `div_busy`  out  1  divider stall counter nonzero.

## Operation
- FSM states: RUN, DRAIN, REDIRECT.
- Stall vector (combinational, highest stage wins):
  - `mem_stall_req` → 4'b1111.
  - `div_busy` or `div_start` → 4'b0111.
  - `id_stall_req` → 4'b0011.
  - `if_stall_req` → 4'b0001.
  - none → 4'b0000.
  - DRAIN or REDIRECT forces 4'b0001 (IF held, downstream bubbles).
- Divider counter (6 bits):
  - `div_start` loads `DIV_CYCLES-1`; decrements each cycle while nonzero.
  - `div_busy` = counter≠0.
  - Total EXE hold is exactly `DIV_CYCLES` cycles.
  - `div_start` while busy is ignored.
- Outstanding counter (2 bits): +1 on `inst_req_fire`, −1 on `inst_resp_fire`; both in the same cycle leaves it unchanged.
- `inst_req_allow` = (state==RUN) && count<`INST_OUTSTANDING_MAX`.
- RUN:
  - `exc_req` && !`mem_stall_req` → accept: `flush`=1 combinationally this cycle, `exc_target` latched.
  - Divider counter cleared on accept.
  - Next state is DRAIN if the next-cycle outstanding count >0, else REDIRECT.
  - `exc_req` during `mem_stall_req` is deferred; no flush.
- DRAIN:
  - `inst_resp_discard`=1; every response decrements the count.
  - Leave for REDIRECT in the cycle after the count reaches 0.
  - `exc_req` is ignored (pipeline is empty).
- REDIRECT: `pc_redirect`=1 for one cycle → RUN.
- `inst_resp_discard`=0 in RUN and REDIRECT.

## Timing
- Reset values:
  - `stall`=0, `flush`=0, `pc_redirect`=0, `pc_redirect_target`=0.
  - `inst_resp_discard`=0, `div_busy`=0, `inst_req_allow`=1.
  - State RUN; both counters 0.
- Reset mid-DRAIN/REDIRECT abandons the sequence; no redirect is issued.
- `flush` is a 1-cycle pulse, same cycle as acceptance; registers clear on that edge.
- Minimum exception-to-redirect latency is 1 cycle (accept at T, `pc_redirect` at T+1, fetch from target at T+2).
- With an in-flight fetch whose response arrives at T+k, `pc_redirect` asserts at T+k+1.
- `stall` and `flush` are combinational from inputs and state; all other outputs are registered.

## Configuration
- `PIPE_CTRL_PERF_EN`: when defined, adds outputs `perf_stall_cycles[4*32-1:0]`.
  - One 32-bit wrapping counter per stall bit, incremented each cycle that bit is 1.
  - Plus `perf_flush_count[31:0]`.
  - All cleared by `rst`.
- When undefined, none of these ports or registers exist; behaviour is otherwise identical.

## Test plan
- `if_stall_req`=1 and `id_stall_req`=1 simultaneously → `stall`=4'b0011; add `mem_stall_req` → 4'b1111.
- `div_start` pulse at T with `DIV_CYCLES`=33 → `stall[2]`=1 for cycles T..T+32, 0 at T+33; second `div_start` at T+5 has no effect.
- `exc_req` with 0 outstanding, `exc_target`=0xBFC00380 → `flush` at T, `pc_redirect`=1 with target 0xBFC00380 at T+1, `stall`=0 at T+2.
- Two fetches outstanding, `exc_req` at T, responses at T+3 and T+6 → both `inst_resp_discard`=1, `pc_redirect` at T+7, `inst_req_allow`=0 during T+1..T+7.
- `exc_req` held during `mem_stall_req` for 4 cycles → no `flush` until the cycle `mem_stall_req` drops, then a single pulse.
- `rst` asserted in DRAIN → next cycle state RUN, counters 0, `pc_redirect` never asserted.

Source files
------------

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_ctrl
// Purpose  : Stall/flush controller for the 5-stage core: stall merge, divider
//            hold counter, exception flush/drain/redirect sequencing.
//            Optional perf counters enabled by PIPE_CTRL_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_ctrl #(
  parameter int DIV_CYCLES           = 33,
  parameter int INST_OUTSTANDING_MAX = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_stall_req,
  input  logic        id_stall_req,
  input  logic        div_start,
  input  logic        mem_stall_req,
  input  logic        exc_req,
  input  logic [31:0] exc_target,
  input  logic        inst_req_fire,
  input  logic        inst_resp_fire,
  output logic [3:0]  stall,
  output logic        flush,
  output logic        inst_req_allow,
  output logic        inst_resp_discard,
  output logic        pc_redirect,
  output logic [31:0] pc_redirect_target,
  output logic        div_busy
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [4*32-1:0] perf_stall_cycles,
  output logic [31:0]     perf_flush_count
`endif
);

  localparam logic [1:0] c_ST_RUN      = 2'd0;
  localparam logic [1:0] c_ST_DRAIN    = 2'd1;
  localparam logic [1:0] c_ST_REDIRECT = 2'd2;

  localparam logic [5:0] c_DIV_LOAD = 6'(DIV_CYCLES - 1);
  localparam logic [1:0] c_OUT_MAX  = 2'(INST_OUTSTANDING_MAX);

  logic [1:0]  state_q, state_d;
  logic [5:0]  div_cnt_q, div_cnt_d;
  logic [1:0]  out_cnt_q, out_cnt_d;
  logic [31:0] target_q, target_d;
  logic        w_accept;

  always_comb begin
    w_accept = !rst && (state_q == c_ST_RUN) && exc_req && !mem_stall_req;
    flush    = w_accept;

    // During the exception sequence IF is held and downstream sees bubbles.
    stall = 4'b0000;
    if (rst) begin
      stall = 4'b0000;
    end else if (state_q != c_ST_RUN) begin
      stall = 4'b0001;
    end else if (mem_stall_req) begin
      stall = 4'b1111;
    end else if ((div_cnt_q != 6'd0) || div_start) begin
      stall = 4'b0111;
    end else if (id_stall_req) begin
      stall = 4'b0011;
    end else if (if_stall_req) begin
      stall = 4'b0001;
    end
  end

  always_comb begin
    out_cnt_d = out_cnt_q;
    case ({inst_req_fire, inst_resp_fire})
      2'b10:   out_cnt_d = out_cnt_q + 2'd1;
      2'b01:   out_cnt_d = out_cnt_q - 2'd1;
      default: out_cnt_d = out_cnt_q;
    endcase

    div_cnt_d = div_cnt_q;
    if (w_accept) begin
      div_cnt_d = 6'd0;
    end else if (div_start && (div_cnt_q == 6'd0)) begin
      div_cnt_d = c_DIV_LOAD;
    end else if (div_cnt_q != 6'd0) begin
      div_cnt_d = div_cnt_q - 6'd1;
    end

    target_d = w_accept ? exc_target : target_q;

    state_d = state_q;
    case (state_q)
      c_ST_RUN: begin
        if (w_accept) begin
          state_d = (out_cnt_d != 2'd0) ? c_ST_DRAIN : c_ST_REDIRECT;
        end
      end
      c_ST_DRAIN: begin
        if (out_cnt_d == 2'd0) begin
          state_d = c_ST_REDIRECT;
        end
      end
      c_ST_REDIRECT: state_d = c_ST_RUN;
      default:       state_d = c_ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= c_ST_RUN;
      div_cnt_q <= 6'd0;
      out_cnt_q <= 2'd0;
      target_q  <= 32'd0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      out_cnt_q <= out_cnt_d;
      target_q  <= target_d;
    end
  end

  assign div_busy           = (div_cnt_q != 6'd0);
  assign inst_req_allow     = (state_q == c_ST_RUN) && (out_cnt_q < c_OUT_MAX);
  assign inst_resp_discard  = (state_q == c_ST_DRAIN);
  assign pc_redirect        = (state_q == c_ST_REDIRECT);
  assign pc_redirect_target = target_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_flush_q;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_perf_stall
      logic [31:0] perf_cnt_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          perf_cnt_q <= 32'd0;
        end else if (stall[gi]) begin
          perf_cnt_q <= perf_cnt_q + 32'd1;
        end
      end
      assign perf_stall_cycles[gi*32 +: 32] = perf_cnt_q;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_flush_q <= 32'd0;
    end else if (flush) begin
      perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign perf_flush_count = perf_flush_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_ctrl
// Purpose  : Self-checking bench for pipeline_ctrl against a cycle-indexed
//            reference model; directed scenarios followed by random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;

  localparam int DIVC = 33;
  localparam int MAXO = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_stall_req, id_stall_req, div_start, mem_stall_req, exc_req;
  logic [31:0] exc_target;
  logic        inst_req_fire, inst_resp_fire;
  logic [3:0]  stall;
  logic        flush, inst_req_allow, inst_resp_discard, pc_redirect, div_busy;
  logic [31:0] pc_redirect_target;
`ifdef PIPE_CTRL_PERF_EN
  logic [4*32-1:0] perf_stall_cycles;
  logic [31:0]     perf_flush_count;
`endif

  always #5 clk = ~clk;

  pipeline_ctrl #(.DIV_CYCLES(DIVC), .INST_OUTSTANDING_MAX(MAXO)) dut (
    .clk(clk), .rst(rst),
    .if_stall_req(if_stall_req), .id_stall_req(id_stall_req),
    .div_start(div_start), .mem_stall_req(mem_stall_req),
    .exc_req(exc_req), .exc_target(exc_target),
    .inst_req_fire(inst_req_fire), .inst_resp_fire(inst_resp_fire),
    .stall(stall), .flush(flush), .inst_req_allow(inst_req_allow),
    .inst_resp_discard(inst_resp_discard), .pc_redirect(pc_redirect),
    .pc_redirect_target(pc_redirect_target), .div_busy(div_busy)
`ifdef PIPE_CTRL_PERF_EN
    , .perf_stall_cycles(perf_stall_cycles), .perf_flush_count(perf_flush_count)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: divider hold tracked as an absolute cycle window.
  typedef enum {P_RUN, P_DRAIN, P_REDIR} phase_t;
  phase_t      m_phase = P_RUN;
  int          m_cyc = 0;
  int          m_div_t = -1;
  int          m_div_last = -1;
  int          m_out = 0;
  logic [31:0] m_tgt = 32'd0;
  bit          m_accepted;

  function automatic bit m_busy();
    return (m_cyc > m_div_t) && (m_cyc <= m_div_last);
  endfunction

  task automatic cyc(input logic a_if, input logic a_id, input logic a_div,
                     input logic a_mem, input logic a_exc, input logic [31:0] a_tgt,
                     input logic a_rq, input logic a_rs, input logic a_rst);
    logic [3:0] e_stall;
    logic       e_flush;
    int         nout;
    @(posedge clk);
    #1;
    if_stall_req = a_if; id_stall_req = a_id; div_start = a_div;
    mem_stall_req = a_mem; exc_req = a_exc; exc_target = a_tgt;
    inst_req_fire = a_rq; inst_resp_fire = a_rs; rst = a_rst;
    @(negedge clk);

    e_flush = !a_rst && (m_phase == P_RUN) && a_exc && !a_mem;
    if (a_rst)                 e_stall = 4'b0000;
    else if (m_phase != P_RUN) e_stall = 4'b0001;
    else if (a_mem)            e_stall = 4'b1111;
    else if (m_busy() || a_div) e_stall = 4'b0111;
    else if (a_id)             e_stall = 4'b0011;
    else if (a_if)             e_stall = 4'b0001;
    else                       e_stall = 4'b0000;

    chk("stall", {28'd0, stall}, {28'd0, e_stall});
    chk("flush", {31'd0, flush}, {31'd0, e_flush});
    chk("req_allow", {31'd0, inst_req_allow}, {31'd0, (m_phase == P_RUN) && (m_out < MAXO)});
    chk("resp_discard", {31'd0, inst_resp_discard}, {31'd0, m_phase == P_DRAIN});
    chk("pc_redirect", {31'd0, pc_redirect}, {31'd0, m_phase == P_REDIR});
    chk("redirect_target", pc_redirect_target, m_tgt);
    chk("div_busy", {31'd0, div_busy}, {31'd0, m_busy()});

    m_accepted = e_flush;
    if (a_rst) begin
      m_phase = P_RUN; m_div_t = -1; m_div_last = -1; m_out = 0; m_tgt = 32'd0;
      m_cyc = 0;
    end else begin
      nout = m_out + int'(a_rq) - int'(a_rs);
      if (e_flush) begin
        m_tgt      = a_tgt;
        m_div_last = m_cyc;
        m_phase    = (nout > 0) ? P_DRAIN : P_REDIR;
      end else begin
        if (a_div && !m_busy()) begin
          m_div_t    = m_cyc;
          m_div_last = m_cyc + DIVC - 1;
        end
        if (m_phase == P_DRAIN && nout == 0) m_phase = P_REDIR;
        else if (m_phase == P_REDIR)         m_phase = P_RUN;
      end
      m_out = nout;
      m_cyc++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 32'd0, 0, 0, 0);
  endtask

  logic        exc_pend;
  logic [31:0] exc_val;
  logic        r_rq, r_rs, r_rst;

  initial begin
    rst = 1'b1;
    {if_stall_req, id_stall_req, div_start, mem_stall_req, exc_req} = '0;
    {inst_req_fire, inst_resp_fire} = '0;
    exc_target = 32'd0;
    cyc(0, 0, 0, 0, 0, 32'd0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 32'd0, 0, 0, 1);
    idle(1);

    // Stall priority
    cyc(1, 1, 0, 0, 0, 32'd0, 0, 0, 0);
    cyc(1, 1, 0, 1, 0, 32'd0, 0, 0, 0);
    idle(1);

    // Divide hold with a second start while busy
    cyc(0, 0, 1, 0, 0, 32'd0, 0, 0, 0);
    idle(4);
    cyc(0, 0, 1, 0, 0, 32'd0, 0, 0, 0);
    idle(32);

    // Exception, nothing in flight
    cyc(0, 0, 0, 0, 1, 32'hBFC00380, 0, 0, 0);
    idle(3);

    // Exception with two fetches in flight
    cyc(0, 0, 0, 0, 0, 32'd0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 32'd0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 32'h8000_0180, 0, 0, 0);
    idle(2);
    cyc(0, 0, 0, 0, 0, 32'd0, 0, 1, 0);
    idle(2);
    cyc(0, 0, 0, 0, 0, 32'd0, 0, 1, 0);
    idle(3);

    // Exception deferred behind a data-bus stall
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 1, 32'h1234_5678, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 32'h1234_5678, 0, 0, 0);
    idle(3);

    // Reset while draining
    cyc(0, 0, 0, 0, 0, 32'd0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 32'hDEAD_BEE0, 0, 0, 0);
    idle(1);
    cyc(0, 0, 0, 0, 0, 32'd0, 0, 0, 1);
    idle(4);

    // Random traffic
    exc_pend = 1'b0;
    exc_val  = 32'd0;
    for (int i = 0; i < 3000; i++) begin
      if (!exc_pend && m_phase == P_RUN && ($urandom % 10) == 0) begin
        exc_pend = 1'b1;
        exc_val  = $urandom;
      end
      r_rq  = (m_phase == P_RUN) && (m_out < MAXO) && (($urandom % 2) == 0);
      r_rs  = (m_out > 0) && (($urandom % 3) == 0);
      r_rst = (($urandom % 200) == 0);
      cyc(($urandom % 4) == 0, ($urandom % 4) == 0, ($urandom % 25) == 0,
          ($urandom % 4) == 0, exc_pend, exc_pend ? exc_val : $urandom,
          r_rq, r_rs, r_rst);
      if (m_accepted || r_rst) exc_pend = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
